gpu_hazard_ctrl: RTL
====================

# gpu_hazard_ctrl

Parametrised hazard controller for the filter GPU's five-stage pipeline (F/D/E/M/W), succeeding the fixed 4-bit-register, single-cycle-memory hazard unit. It adds a configurable register-address width, a multi-cycle memory wait state machine that freezes the pipeline while a load sits in M, and a compile-time choice between forwarding and a scoreboard-interlocked (no-forwarding) mode. It sits beside the datapath and drives every stall, flush and forward select.

## Interface
Parameters:
- REG_AW, 4: register address width; 2**REG_AW architectural registers.
- MEM_LAT, 2: extra cycles a load occupies M (0 = single-cycle memory).

Ports (clock and reset first):
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- RA1D, RA2D  in  REG_AW  source registers of the instruction in D.
- WA3D  in  REG_AW  destination of the instruction in D.
- RegWriteD  in  1  D instruction writes a register.
- ValidD  in  1  D holds a real instruction (not a bubble).
- RA1E, RA2E, WA3E  in  REG_AW  sources/destination in E.
- MemtoRegE  in  1  E instruction is a load.
- WA3M  in  REG_AW;  RegWriteM, MemtoRegM  in  1  M-stage destination/controls.
- WA3W  in  REG_AW;  RegWriteW  in  1  W-stage destination/write enable.
- StallF, StallD, StallE, StallM  out  1  hold the stage's pipeline register.
- FlushE, FlushW  out  1  insert bubble into E / W.
- ForwardAE, ForwardBE  out  2  E operand select: 00 register file, 01 W result, 10 M ALU result.

## Operation
- Memory-wait FSM, states IDLE, WAIT, DONE; counter width $clog2(MEM_LAT+1).
  - IDLE: if MemtoRegM and MEM_LAT>0 -> WAIT, counter <= MEM_LAT-1. Stall outputs asserted in the same cycle (combinational on IDLE & MemtoRegM).
  - WAIT: counter decrements; at counter==0 -> DONE.
  - DONE: no memory stall; load leaves M at end of cycle -> IDLE. A load arriving in M next cycle is evaluated fresh in IDLE.
  - Memory stall active (IDLE&MemtoRegM, or WAIT): StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0, forwards still computed. Load therefore occupies M exactly MEM_LAT+1 cycles.
- Load-use stall (outside memory stall): MemtoRegE & (WA3E==RA1D | WA3E==RA2D) -> StallF=StallD=FlushE=1.
- Forwarding, per operand (A shown, B identical with RA2E): RegWriteM & WA3M==RA1E -> 10; else RegWriteW & WA3W==RA1E -> 01; else 00. M has priority.
- Scoreboard (only when forwarding compiled out, see Configuration): NREGS bits.
  - Set bit WA3D when ValidD & RegWriteD & the D->E transfer occurs (StallD=0, FlushE=0).
  - Clear bit WA3W when RegWriteW.
  - Same register set and cleared in one cycle: set wins.
  - Interlock: pending[RAxD] & !(RegWriteW & WA3W==RAxD) for either source -> StallF=StallD=FlushE=1 (register file is write-through).
- RST high: FSM <= IDLE, counter <= 0, scoreboard cleared; outputs during reset: all Stall*=0, FlushE=FlushW=1, Forward*=00. Reset mid-WAIT abandons the wait.

## Timing
- Forward selects and stall/flush outputs are combinational from inputs and current state; zero-cycle latency.
- Load-use stall lasts 1 cycle; memory stall lasts MEM_LAT cycles per load; both in sequence for a dependent load (consumer stays in D throughout).
- Scoreboard and FSM update on the CLK edge; a bit set in cycle n is visible to D in cycle n+1.

## Configuration
- HAZARD_FWD_EN defined: forwarding mux selects and load-use stall as above; scoreboard not built.
- HAZARD_FWD_EN undefined: ForwardAE=ForwardBE=00 always; load-use check replaced by scoreboard interlock; memory-wait FSM unchanged.

## Test plan
- Forwarding (FWD_EN): ALU writes r3 in M, E reads r3 on A and W also writes r3 -> ForwardAE=10; with only W writing r3 -> 01.
- Load-use (FWD_EN, MEM_LAT=0): load r5 in E, D reads r5 -> StallF/StallD/FlushE=1 one cycle, then consumer in E gets ForwardAE=01.
- Memory wait (MEM_LAT=2): load enters M -> StallF/D/E/M=FlushW=1 for exactly 2 cycles, DONE cycle clean; back-to-back loads -> two separate 2-cycle stalls.
- Scoreboard (no FWD_EN): write to r7 issued, dependent D instruction stalls until cycle W writes r7, then issues that same cycle; set/clear of r7 in one cycle leaves bit set.
- Reset mid-WAIT (MEM_LAT=3): RST in second wait cycle -> next cycle FSM IDLE, all stalls 0, scoreboard zero.
- REG_AW=6: hazard on r45 vs r13 distinguished (no aliasing of upper address bits).

Source files
------------

// File: rtl/gpu_hazard_ctrl.sv
// Hazard controller for the five-stage filter GPU pipeline: stalls, flushes, forward selects.
// Define HAZARD_FWD_EN for forwarding + load-use stalls; otherwise a scoreboard interlock is built.
module gpu_hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              ValidD,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic              MemtoRegE,
  input  logic [REG_AW-1:0] WA3M,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam bit HAS_LAT = (MEM_LAT > 0);
  localparam bit LAT_ONE = (MEM_LAT == 1);
  localparam logic [CW-1:0] LAT_M1 = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic          w_memStall;
  logic          w_hazard;
  logic [1:0]    w_fwdA;
  logic [1:0]    w_fwdB;

  // The stall starts in the IDLE cycle the load shows up, so WAIT only covers the remaining MEM_LAT-1 cycles.
  assign w_memStall = (r_state == S_IDLE && MemtoRegM && HAS_LAT) || (r_state == S_WAIT);

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (MemtoRegM && HAS_LAT) begin
          w_cntNext   = LAT_M1;
          w_stateNext = LAT_ONE ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cntNext = r_cnt - CNT_ONE;
        if (w_cntNext == '0) w_stateNext = S_DONE;
      end
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

`ifdef HAZARD_FWD_EN
  logic w_unused;
  assign w_unused = ^{WA3D, RegWriteD, ValidD};

  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (RegWriteM && WA3M == RA1E)      w_fwdA = 2'b10;
    else if (RegWriteW && WA3W == RA1E) w_fwdA = 2'b01;
    if (RegWriteM && WA3M == RA2E)      w_fwdB = 2'b10;
    else if (RegWriteW && WA3W == RA2E) w_fwdB = 2'b01;
  end

  assign w_hazard = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
`else
  localparam int NREGS = 1 << REG_AW;

  logic             w_unused;
  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_setMask;
  logic [NREGS-1:0] w_clrMask;
  logic             w_pendA;
  logic             w_pendB;

  assign w_unused = ^{RA1E, RA2E, WA3E, MemtoRegE, WA3M, RegWriteM};
  assign w_fwdA   = 2'b00;
  assign w_fwdB   = 2'b00;

  always_comb begin
    w_setMask = '0;
    w_clrMask = '0;
    if (ValidD && RegWriteD && !StallD && !FlushE) w_setMask[WA3D] = 1'b1;
    if (RegWriteW) w_clrMask[WA3W] = 1'b1;
  end

  // Set is applied after clear so a register re-issued in its own writeback cycle stays pending.
  always_ff @(posedge CLK) begin
    if (RST) r_pend <= '0;
    else     r_pend <= (r_pend & ~w_clrMask) | w_setMask;
  end

  assign w_pendA  = r_pend[RA1D] && !(RegWriteW && WA3W == RA1D);
  assign w_pendB  = r_pend[RA2D] && !(RegWriteW && WA3W == RA2D);
  assign w_hazard = w_pendA || w_pendB;
`endif

  // Reset outranks the memory stall, which outranks the dependency stall.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = w_fwdA;
    ForwardBE = w_fwdB;
    if (RST) begin
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else if (w_memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (w_hazard) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

endmodule
